input_debounce_2ch: RTL and testbench

//  Conditions two raw asynchronous digital inputs (pushbuttons/switches) for the logic gate stage.
//  Per channel: metastability synchroniser, then counter-based debounce FSM.

---
 rtl/input_debounce_2ch.sv | 138 +++++++++++++
 tb/tb_input_debounce_2ch.sv | 138 +++++++++++++
 2 files changed

// File: rtl/input_debounce_2ch.sv
// Two-channel input conditioner: a synchroniser chain and a counter-based debounce FSM per
// channel, producing registered clean levels plus one-cycle rise/fall strobes.
module input_debounce_2ch #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic in_a,
    input  logic in_b,
    output logic a_clean,
    output logic b_clean,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_RISING  = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [1:0] ST_FALLING = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] w_pin;
    logic [1:0] w_clean;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    assign w_pin = {in_b, in_a};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [1:0]             r_state;
        logic [1:0]             w_state_d;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_d;
        logic                   r_clean;
        logic                   w_clean_d;
        logic                   r_rise;
        logic                   w_rise_d;
        logic                   r_fall;
        logic                   w_fall_d;
        logic                   w_s;

        assign w_s = r_sync[SYNC_STAGES-1];

        always_comb begin
            w_state_d = r_state;
            w_cnt_d   = r_cnt;
            w_clean_d = r_clean;
            w_rise_d  = 1'b0;
            w_fall_d  = 1'b0;
            case (r_state)
                ST_LOW: begin
                    if (w_s) begin
                        w_state_d = ST_RISING;
                        w_cnt_d   = CNT_ONE;
                    end else begin
                        w_cnt_d   = '0;
                    end
                end
                ST_RISING: begin
                    if (!w_s) begin
                        w_state_d = ST_LOW;
                        w_cnt_d   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_d = ST_HIGH;
                        w_cnt_d   = '0;
                        w_clean_d = 1'b1;
                        w_rise_d  = 1'b1;
                    end else begin
                        w_cnt_d   = r_cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!w_s) begin
                        w_state_d = ST_FALLING;
                        w_cnt_d   = CNT_ONE;
                    end else begin
                        w_cnt_d   = '0;
                    end
                end
                ST_FALLING: begin
                    if (w_s) begin
                        w_state_d = ST_HIGH;
                        w_cnt_d   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_d = ST_LOW;
                        w_cnt_d   = '0;
                        w_clean_d = 1'b0;
                        w_fall_d  = 1'b1;
                    end else begin
                        w_cnt_d   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_d = ST_LOW;
                    w_cnt_d   = '0;
                    w_clean_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync  <= '0;
                r_state <= ST_LOW;
                r_cnt   <= '0;
                r_clean <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], w_pin[g]};
                r_state <= w_state_d;
                r_cnt   <= w_cnt_d;
                r_clean <= w_clean_d;
                r_rise  <= w_rise_d;
                r_fall  <= w_fall_d;
            end
        end

        assign w_clean[g] = r_clean;
        assign w_rise[g]  = r_rise;
        assign w_fall[g]  = r_fall;
    end

    assign a_clean = w_clean[0];
    assign b_clean = w_clean[1];
    assign a_rise  = w_rise[0];
    assign b_rise  = w_rise[1];
    assign a_fall  = w_fall[0];
    assign b_fall  = w_fall[1];

endmodule

// File: tb/tb_input_debounce_2ch.sv
// Directed bench for input_debounce_2ch with STABLE_CYCLES=4, SYNC_STAGES=2 (6-edge latency).
module tb_input_debounce_2ch;

    logic clk = 1'b0;
    logic rst;
    logic in_a;
    logic in_b;
    logic a_clean, b_clean, a_rise, a_fall, b_rise, b_fall;
    logic [5:0] w_outs;

    int n_checks = 0;
    int n_errors = 0;
    logic ea = 1'b0;
    logic eb = 1'b0;

    always #5 clk = ~clk;

    input_debounce_2ch #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .CNT_W        (20)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .in_a   (in_a),
        .in_b   (in_b),
        .a_clean(a_clean),
        .b_clean(b_clean),
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall)
    );

    // Packed as {a_clean, a_rise, a_fall, b_clean, b_rise, b_fall}
    assign w_outs = {a_clean, a_rise, a_fall, b_clean, b_rise, b_fall};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Six edges from the capturing edge; selected channels toggle (with strobe) on the sixth.
    task automatic transition(input string tag, input bit ch_a, input bit ch_b);
        logic [5:0] exp;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) begin
                if (ch_a) ea = ~ea;
                if (ch_b) eb = ~eb;
                exp = {ea, ch_a & ea, ch_a & ~ea, eb, ch_b & eb, ch_b & ~eb};
            end else begin
                exp = {ea, 2'b00, eb, 2'b00};
            end
            chk($sformatf("%s_e%0d", tag, k), {26'd0, w_outs}, {26'd0, exp});
        end
        tick();
        chk($sformatf("%s_hold", tag), {26'd0, w_outs}, {26'd0, ea, 2'b00, eb, 2'b00});
    endtask

    task automatic quiet(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            chk($sformatf("%s_q%0d", tag, k), {26'd0, w_outs}, {26'd0, ea, 2'b00, eb, 2'b00});
        end
    endtask

    initial begin
        rst  = 1'b1;
        in_a = 1'b1;
        in_b = 1'b1;
        #23;
        chk("rst_outs", {26'd0, w_outs}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // 1: both inputs held high through reset rise together
        transition("t1", 1'b1, 1'b1);

        // 5: falling edge on A
        in_a = 1'b0;
        transition("t5", 1'b1, 1'b0);

        // 2: clean step on A, then back down
        in_a = 1'b1;
        transition("t2", 1'b1, 1'b0);
        in_a = 1'b0;
        transition("t2f", 1'b1, 1'b0);

        // 3: bounce 1,0,1,1,0 then stable 1
        in_a = 1'b1; quiet("t3b0", 1);
        in_a = 1'b0; quiet("t3b1", 1);
        in_a = 1'b1; quiet("t3b2", 2);
        in_a = 1'b0; quiet("t3b3", 1);
        in_a = 1'b1;
        transition("t3", 1'b1, 1'b0);

        // 4: bring B low, then a 3-cycle glitch must be rejected
        in_b = 1'b0;
        transition("t4pre", 1'b0, 1'b1);
        in_b = 1'b1;
        quiet("t4g", 3);
        in_b = 1'b0;
        quiet("t4", 10);

        // 6: B high, A low, then reset in the middle of an A rising count
        in_b = 1'b1;
        transition("t6b", 1'b0, 1'b1);
        in_a = 1'b0;
        transition("t6pre", 1'b1, 1'b0);
        in_a = 1'b1;
        quiet("t6cnt", 4);
        #2;
        rst = 1'b1;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        chk("t6_async", {26'd0, w_outs}, 32'd0);
        tick();
        chk("t6_inrst", {26'd0, w_outs}, 32'd0);
        #2;
        rst = 1'b0;
        transition("t6", 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
